// File: rtl/gpu_queue_pkg.sv
// Shared types for the GPU instruction queue: packed draw-instruction layout and word width.
package gpu_queue_pkg;

  localparam int CHANNEL_BITS = 8;
  localparam int WIDTH_BITS   = 10;
  localparam int HEIGHT_BITS  = 9;

  // opcode sits in the LSBs; the field order below fixes the packed bit layout
  typedef struct packed {
    logic [2:0]              quad;
    logic [CHANNEL_BITS-1:0] b;
    logic [CHANNEL_BITS-1:0] g;
    logic [CHANNEL_BITS-1:0] r;
    logic [WIDTH_BITS-1:0]   rad;
    logic [HEIGHT_BITS-1:0]  y2;
    logic [WIDTH_BITS-1:0]   x2;
    logic [HEIGHT_BITS-1:0]  y1;
    logic [WIDTH_BITS-1:0]   x1;
    logic [3:0]              opcode;
  } instr_t;

  localparam int INSTR_W = $bits(instr_t);

endpackage

// File: rtl/gpu_queue_ctrl.sv
// Queue bookkeeping: pointers, occupancy, push/pop acceptance, status flags and sticky errors.
module gpu_queue_ctrl #(
  parameter  int DEPTH        = 8,
  parameter  int AFULL_THRESH = DEPTH - 2,
  localparam int PTR_W        = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             n_rst,
  input  logic             i_push,
  input  logic             i_pop,
  input  logic             i_flush,
  input  logic             i_clear_err,
  output logic             o_push_acc,
  output logic [PTR_W-1:0] o_wr_ptr,
  output logic [PTR_W-1:0] o_rd_ptr,
  output logic [PTR_W:0]   o_count,
  output logic             o_empty,
  output logic             o_full,
  output logic             o_almost_full,
  output logic             o_overflow,
  output logic             o_underflow
);

  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [PTR_W:0]   r_count;
  logic             r_overflow;
  logic             r_underflow;
  logic             w_push_acc;
  logic             w_pop_acc;
  logic             w_empty;
  logic             w_full;

  assign w_empty = (r_count == '0);
  assign w_full  = (r_count == (PTR_W+1)'(DEPTH));

  // A full queue can still take a push when a pop frees a slot in the same cycle.
  assign w_pop_acc  = i_pop & ~w_empty & ~i_flush;
  assign w_push_acc = i_push & ~i_flush & (~w_full | w_pop_acc);

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
      r_count     <= '0;
      r_overflow  <= 1'b0;
      r_underflow <= 1'b0;
    end else begin
      if (i_flush) begin
        r_wr_ptr <= '0;
        r_rd_ptr <= '0;
        r_count  <= '0;
      end else begin
        if (w_push_acc) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
        if (w_pop_acc)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
        case ({w_push_acc, w_pop_acc})
          2'b10:   r_count <= r_count + (PTR_W+1)'(1);
          2'b01:   r_count <= r_count - (PTR_W+1)'(1);
          default: r_count <= r_count;
        endcase
      end
      // Set beats clear so a rejection in the clearing cycle is never lost.
      if (i_push & ~i_flush & ~w_push_acc) r_overflow <= 1'b1;
      else if (i_clear_err)                r_overflow <= 1'b0;
      if (i_pop & ~i_flush & ~w_pop_acc)   r_underflow <= 1'b1;
      else if (i_clear_err)                r_underflow <= 1'b0;
    end
  end

  assign o_push_acc    = w_push_acc;
  assign o_wr_ptr      = r_wr_ptr;
  assign o_rd_ptr      = r_rd_ptr;
  assign o_count       = r_count;
  assign o_empty       = w_empty;
  assign o_full        = w_full;
  assign o_almost_full = (r_count >= (PTR_W+1)'(AFULL_THRESH));
  assign o_overflow    = r_overflow;
  assign o_underflow   = r_underflow;

endmodule

// File: rtl/gpu_instruction_queue.sv
// First-word fall-through instruction FIFO between the command decoder and the rasteriser.
module gpu_instruction_queue
  import gpu_queue_pkg::*;
#(
  parameter  int DATA_W       = INSTR_W,
  parameter  int DEPTH        = 8,
  parameter  int AFULL_THRESH = DEPTH - 2,
  localparam int PTR_W        = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              n_rst,
  input  logic              push_i,
  input  logic [DATA_W-1:0] data_i,
  input  logic              pop_i,
  input  logic              flush_i,
  input  logic              clear_err_i,
  output logic [DATA_W-1:0] data_o,
  output logic              empty_o,
  output logic              full_o,
  output logic              almost_full_o,
  output logic [PTR_W:0]    count_o,
  output logic              overflow_o,
  output logic              underflow_o
);

  logic [DATA_W-1:0] r_mem [DEPTH];
  logic              w_push_acc;
  logic [PTR_W-1:0]  w_wr_ptr;
  logic [PTR_W-1:0]  w_rd_ptr;
  logic              w_empty;

  gpu_queue_ctrl #(
    .DEPTH        (DEPTH),
    .AFULL_THRESH (AFULL_THRESH)
  ) u_ctrl (
    .clk           (clk),
    .n_rst         (n_rst),
    .i_push        (push_i),
    .i_pop         (pop_i),
    .i_flush       (flush_i),
    .i_clear_err   (clear_err_i),
    .o_push_acc    (w_push_acc),
    .o_wr_ptr      (w_wr_ptr),
    .o_rd_ptr      (w_rd_ptr),
    .o_count       (count_o),
    .o_empty       (w_empty),
    .o_full        (full_o),
    .o_almost_full (almost_full_o),
    .o_overflow    (overflow_o),
    .o_underflow   (underflow_o)
  );

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
    end else if (w_push_acc) begin
      r_mem[w_wr_ptr] <= data_i;
    end
  end

  // Stale storage is masked so an empty (or freshly flushed) queue always reads zero.
  assign data_o  = w_empty ? '0 : r_mem[w_rd_ptr];
  assign empty_o = w_empty;

endmodule

// File: tb/tb_gpu_instruction_queue.sv
// Directed scoreboard bench for gpu_instruction_queue (DEPTH=8, AFULL_THRESH=6).
module tb_gpu_instruction_queue;
  import gpu_queue_pkg::*;

  localparam int W     = INSTR_W;
  localparam int DEPTH = 8;
  localparam int AF    = DEPTH - 2;

  logic         clk = 1'b0;
  logic         n_rst;
  logic         push_i, pop_i, flush_i, clear_err_i;
  logic [W-1:0] data_i;
  logic [W-1:0] data_o;
  logic         empty_o, full_o, almost_full_o, overflow_o, underflow_o;
  logic [3:0]   count_o;

  int total = 0;
  int bad   = 0;
  logic [W-1:0] q[$];
  logic m_ovf = 1'b0;
  logic m_udf = 1'b0;

  always #5 clk = ~clk;

  gpu_instruction_queue #(.DATA_W(W), .DEPTH(DEPTH), .AFULL_THRESH(AF)) dut (
    .clk(clk), .n_rst(n_rst), .push_i(push_i), .data_i(data_i), .pop_i(pop_i),
    .flush_i(flush_i), .clear_err_i(clear_err_i), .data_o(data_o), .empty_o(empty_o),
    .full_o(full_o), .almost_full_o(almost_full_o), .count_o(count_o),
    .overflow_o(overflow_o), .underflow_o(underflow_o)
  );

  task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_state(input string tag);
    int n;
    n = q.size();
    check({tag, ":count"}, W'(count_o), W'(n));
    check({tag, ":empty"}, W'(empty_o), W'(n == 0));
    check({tag, ":full"},  W'(full_o),  W'(n == DEPTH));
    check({tag, ":afull"}, W'(almost_full_o), W'(n >= AF));
    check({tag, ":ovf"},   W'(overflow_o),  W'(m_ovf));
    check({tag, ":udf"},   W'(underflow_o), W'(m_udf));
    check({tag, ":data"},  data_o, (n == 0) ? '0 : q[0]);
  endtask

  // One clock with the given inputs; the scoreboard predicts acceptance from its own occupancy.
  task automatic cycle(input string tag, input logic p, input logic [W-1:0] d,
                       input logic po, input logic fl, input logic cl);
    logic m_pop, m_push;
    push_i = p; data_i = d; pop_i = po; flush_i = fl; clear_err_i = cl;
    m_pop  = po && (q.size() != 0) && !fl;
    m_push = p && !fl && ((q.size() < DEPTH) || m_pop);
    if (m_pop) check({tag, ":pop_data"}, data_o, q[0]);
    @(posedge clk); #1;
    if (fl) q.delete();
    else begin
      if (m_pop)  void'(q.pop_front());
      if (m_push) q.push_back(d);
    end
    if (p && !fl && !m_push) m_ovf = 1'b1; else if (cl) m_ovf = 1'b0;
    if (po && !fl && !m_pop) m_udf = 1'b1; else if (cl) m_udf = 1'b0;
    push_i = 1'b0; pop_i = 1'b0; flush_i = 1'b0; clear_err_i = 1'b0; data_i = '0;
    check_state(tag);
    $display("%0t %s push=%0b pop=%0b flush=%0b clr=%0b din=%0h -> count=%0d dout=%0h",
             $time, tag, p, po, fl, cl, d, count_o, data_o);
  endtask

  initial begin
    instr_t ins;
    n_rst = 1'b0; push_i = 1'b0; pop_i = 1'b0; flush_i = 1'b0; clear_err_i = 1'b0; data_i = '0;
    repeat (2) @(posedge clk);
    #1 n_rst = 1'b1;
    check_state("reset");
    cycle("idle", 1'b0, '0, 1'b0, 1'b0, 1'b0);

    for (int i = 0; i < DEPTH; i++) cycle("fill", 1'b1, W'(8'h11 + i), 1'b0, 1'b0, 1'b0);
    cycle("push_full", 1'b1, W'(8'h99), 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < DEPTH; i++) cycle("drain", 1'b0, '0, 1'b1, 1'b0, 1'b0);
    cycle("clr_ovf", 1'b0, '0, 1'b0, 1'b0, 1'b1);

    for (int i = 0; i < DEPTH; i++) cycle("fill2", 1'b1, W'(8'h11 + i), 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < DEPTH; i++) cycle("pushpop_full", 1'b1, W'(8'h20 + i), 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < DEPTH; i++) cycle("drain2", 1'b0, '0, 1'b1, 1'b0, 1'b0);

    for (int i = 0; i < 5; i++) cycle("wrap_push5", 1'b1, W'(8'h40 + i), 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) cycle("wrap_pop5", 1'b0, '0, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 6; i++) begin
      ins = '0;
      ins.opcode = 4'(i + 1);
      ins.x1     = 10'(100 + i);
      ins.r      = 8'hF0;
      ins.quad   = 3'(i);
      cycle("wrap_push6", 1'b1, W'(ins), 1'b0, 1'b0, 1'b0);
    end
    for (int i = 0; i < 6; i++) cycle("wrap_pop6", 1'b0, '0, 1'b1, 1'b0, 1'b0);

    cycle("pushpop_empty", 1'b1, W'(8'hAB), 1'b1, 1'b0, 1'b0);
    cycle("clr_udf", 1'b0, '0, 1'b0, 1'b0, 1'b1);
    cycle("pop_last", 1'b0, '0, 1'b1, 1'b0, 1'b0);

    for (int i = 0; i < 4; i++) cycle("fill4", 1'b1, W'(8'h60 + i), 1'b0, 1'b0, 1'b0);
    cycle("flush_push", 1'b1, W'(8'h77), 1'b1, 1'b1, 1'b0);
    cycle("after_flush", 1'b1, W'(8'h78), 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 2; i++) cycle("refill", 1'b1, W'(8'h80 + i), 1'b0, 1'b0, 1'b0);

    #2 n_rst = 1'b0;
    #1;
    q.delete(); m_ovf = 1'b0; m_udf = 1'b0;
    check_state("async_reset");
    @(posedge clk); #1 n_rst = 1'b1;
    cycle("post_reset", 1'b1, W'(8'h5A), 1'b0, 1'b0, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/gpu_instruction_queue.md
Name: gpu_instruction_queue

Overview:
- Parametrised successor to the fixed 8-deep, 79-bit GPU instruction FIFO.
- Buffers packed draw instructions between the command decoder (producer) and the rasteriser (consumer).
- Adds parametrised width and depth, a single push-with-data handshake (no separate write enable), and legal simultaneous push/pop when full.
- Also adds synchronous flush, an almost-full threshold, occupancy output and sticky overflow/underflow error flags.

Parameters:
- DATA_W, 79, instruction word width in bits (gpu_queue_pkg::INSTR_W).
- DEPTH, 8, number of entries; must be a power of two, >= 2.
- AFULL_THRESH, DEPTH-2, almost_full_o asserts when count >= this value; legal range 1..DEPTH.
- PTR_W, $clog2(DEPTH), derived localparam, not overridable.

Ports:
- clk  in  1  system clock, all state updates on posedge.
- n_rst  in  1  asynchronous active-low reset.
- push_i  in  1  producer request to enqueue data_i.
- data_i  in  DATA_W  instruction word, sampled on an accepted push.
- pop_i  in  1  consumer request to dequeue the head entry.
- flush_i  in  1  synchronous discard of all entries.
- clear_err_i  in  1  clears the sticky error flags.
- data_o  out  DATA_W  head entry (first-word fall-through); all-zero when empty.
- empty_o  out  1  count == 0.
- full_o  out  1  count == DEPTH.
- almost_full_o  out  1  count >= AFULL_THRESH.
- count_o  out  PTR_W+1  current occupancy, 0..DEPTH.
- overflow_o  out  1  sticky: a push was rejected.
- underflow_o  out  1  sticky: a pop was rejected.

Behaviour:
- Reset (async, n_rst low): rd_ptr=0, wr_ptr=0, count=0, all storage=0, overflow_o=0, underflow_o=0. Resulting outputs: empty_o=1, full_o=0, almost_full_o=0, data_o=0. Reset mid-operation discards all contents immediately.
- pop_acc = pop_i & ~empty_o & ~flush_i.
- push_acc = push_i & ~flush_i & (~full_o | pop_acc). A push while full is accepted only if a pop is accepted in the same cycle.
- Push on empty with a simultaneous pop: push accepted, pop rejected. underflow_o sets; the new word appears on data_o the next cycle.
- On push_acc: mem[wr_ptr] <= data_i; wr_ptr <= wr_ptr+1, wrapping modulo DEPTH.
- On pop_acc: rd_ptr <= rd_ptr+1, wrapping modulo DEPTH.
- count: +1 on push only, -1 on pop only, unchanged when both or neither are accepted. count never exceeds DEPTH and never goes below 0.
- flush_i has highest priority. Next cycle: rd_ptr=wr_ptr=0, count=0. Storage is not cleared. Error flags are unaffected. Push and pop in the same cycle as a flush are ignored and do not set the error flags.
- data_o = empty_o ? 0 : mem[rd_ptr], combinational from registered state. Zero latency from pointer update: a word written at edge N is visible on data_o after edge N when the queue was empty.
- empty_o, full_o, almost_full_o and count_o are derived combinationally from the registered count only; there is no combinational path from push_i/pop_i.
- overflow_o sets when push_i & ~flush_i & ~push_acc. underflow_o sets when pop_i & ~flush_i & ~pop_acc. clear_err_i clears both flags; a set condition wins over clear in the same cycle.
- Storage: DEPTH x DATA_W flop array, asynchronously reset to 0.

Decomposition:
- gpu_queue_pkg: INSTR_W=79.
- gpu_queue_pkg: instr_t packed struct {quad[2:0], b, g, r [CHANNEL_BITS], rad [WIDTH_BITS], y2 [HEIGHT_BITS], x2 [WIDTH_BITS], y1 [HEIGHT_BITS], x1 [WIDTH_BITS], opcode[3:0]}, with opcode in the LSBs. Field packing and unpacking go through this struct only; no hand-computed slice indices.
- Sub-module gpu_queue_ctrl: pointers, count, accept logic, flags and error flags.
- Top level (gpu_instruction_queue) holds the storage array and the read mux.

Test Plan:
- Reset then idle -> empty_o=1, count_o=0, data_o=0, full_o=0, overflow_o=0, underflow_o=0.
- Push 0x11..0x18 (DEPTH=8) on consecutive cycles -> full_o=1 after the 8th push, almost_full_o=1 from count 6. A 9th push -> rejected, overflow_o=1, contents unchanged. Then 8 pops -> data_o sequence 0x11..0x18, empty_o=1 after the last pop.
- Fill to 8, then hold push=pop=1 with data 0x20..0x27 for 8 cycles -> count_o stays 8, data_o sequence 0x11..0x18, then 0x20 at the head. No overflow.
- Wrap-around: push 5, pop 5, push 6 -> pointers wrap. Pops return the last 6 words in order, count_o tracks 0..6 exactly.
- Pop on empty with push=1 in the same cycle, data 0xAB -> count_o=1, data_o=0xAB next cycle, underflow_o=1. Then clear_err_i -> underflow_o=0.
- Fill to 4, assert flush_i together with push=1 -> count_o=0, empty_o=1, push ignored, no error flags. Then assert n_rst low mid-fill -> all outputs at reset values immediately.
